sar_search_controller: RTL and testbench

//  Successive-approximation search engine; it drives the comparator from the operand side.

---
 rtl/sar_search_controller_if.sv | 31 +++
 rtl/sar_search_controller.sv | 128 ++++++++++++
 tb/tb_sar_search_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sar_search_controller_if.sv
// rtl/sar_search_controller_if.sv - start/comparator/result bundle for the SAR search controller
// Purpose: groups the search handshake and comparator-facing signals.
// Signals:
//   start                  search request into the controller
//   cmp_gt/cmp_eq/cmp_lt   comparator flags (target vs guess) into the controller
//   guess                  trial value out to the comparator b input
//   busy/done/result/err   search status and outcome out of the controller
// Modports: slave = controller side, master = requester/comparator side.
interface sar_search_controller_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport slave (
    input  start, cmp_gt, cmp_eq, cmp_lt,
    output guess, busy, done, result, err
  );

  modport master (
    output start, cmp_gt, cmp_eq, cmp_lt,
    input  guess, busy, done, result, err
  );
endinterface

// File: rtl/sar_search_controller.sv
// rtl/sar_search_controller.sv - successive-approximation search engine driving a magnitude comparator
// Purpose: resolves an unknown target MSB-first, one bit per clock, by driving trial
//   values on guess and consuming the comparator's gt/eq/lt flags (a=target, b=guess).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sar_search_controller_if.slave: start, cmp_gt/eq/lt in; guess, busy, done, result, err out
// Optional feature macro: SAR_EARLY_EXIT_EN (stop the search on cmp_eq; undefined by default).
module sar_search_controller #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sar_search_controller_if.slave        bus
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             flags_onehot;
  logic [WIDTH-1:0] guess_fixed;
  logic [IW-1:0]    bit_idx_m1;

  assign flags_onehot = $onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});
  assign bit_idx_m1   = bit_idx_q - IW'(1);

  // Current guess with the bit under test corrected. A malformed flag set keeps the bit.
  always_comb begin
    guess_fixed = guess_q;
    if (flags_onehot && bus.cmp_lt) begin
      guess_fixed[bit_idx_q] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    guess_d   = guess_q;
    bit_idx_d = bit_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          guess_d   = WIDTH'(1) << (WIDTH - 1);
          bit_idx_d = IW'(WIDTH - 1);
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_PROBE;
        end
      end

      S_PROBE: begin
        if (!flags_onehot) begin
          err_d = 1'b1;
        end
`ifdef SAR_EARLY_EXIT_EN
        // Bits below bit_idx are still 0, so guess already equals the target exactly.
        if (flags_onehot && bus.cmp_eq) begin
          result_d = guess_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else
`endif
        if (bit_idx_q != '0) begin
          guess_d             = guess_fixed;
          guess_d[bit_idx_m1] = 1'b1;
          bit_idx_d           = bit_idx_m1;
        end else begin
          guess_d  = guess_fixed;
          result_d = guess_fixed;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      guess_q   <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      guess_q   <= guess_d;
      bit_idx_q <= bit_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_controller.sv
// tb/tb_sar_search_controller.sv - randomized self-checking bench for sar_search_controller
module tb_sar_search_controller;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   target;
  bit   fault;
  int   n_checks;
  int   n_fail;
  int   exp_g[$];
  int   exp_res;
  bit   exp_err;

  sar_search_controller_if #(.WIDTH(W)) bus ();

  sar_search_controller #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Combinational comparator; fault forces gt and lt together.
  assign bus.cmp_gt = fault ? 1'b1 : (target > int'(bus.guess));
  assign bus.cmp_lt = fault ? 1'b1 : (target < int'(bus.guess));
  assign bus.cmp_eq = (target == int'(bus.guess));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Binary search by arithmetic: acc holds the resolved prefix, each probe tries the next bit.
  task automatic model(input int tgt, input int fp);
    int acc;
    int g;
    acc = 0;
    exp_err = 1'b0;
    exp_g.delete();
    for (int k = 0; k < W; k++) begin
      g = acc | (1 << (W - 1 - k));
      exp_g.push_back(g);
      if (k == fp) begin
        exp_err = 1'b1;
        acc = g;
      end else if (tgt >= g) begin
        acc = g;
`ifdef SAR_EARLY_EXIT_EN
        if (tgt == g) break;
`endif
      end
    end
    exp_res = acc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full search; restart_at >= 0 pulses start during that probe (must be ignored).
  task automatic run_search(input int tgt, input int fp, input int restart_at);
    int n;
    target = tgt;
    model(tgt, fp);
    n = exp_g.size();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("guess t%0d p%0d", tgt, k), bus.guess, exp_g[k]);
      check_eq("busy_in_probe", bus.busy, 1);
      check_eq("done_in_probe", bus.done, 0);
      fault = (k == fp);
      bus.start = (k == restart_at);
      step();
      fault = 1'b0;
      bus.start = 1'b0;
    end
    check_eq($sformatf("done t%0d", tgt), bus.done, 1);
    check_eq($sformatf("result t%0d", tgt), bus.result, exp_res);
    check_eq($sformatf("err t%0d", tgt), bus.err, exp_err);
    check_eq("busy_at_done", bus.busy, 0);
    step();
    check_eq("done_single_pulse", bus.done, 0);
    check_eq("result_held", bus.result, exp_res);
    check_eq("err_held", bus.err, exp_err);
    step();
    check_eq("idle_no_restart", bus.busy, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    fault = 1'b0;
    target = 0;
    bus.start = 1'b0;
    rst_n = 1'b0;
    step();
    check_eq("rst_guess", bus.guess, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_err", bus.err, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_hold_busy", bus.busy, 0);

    // Directed patterns and boundaries.
    run_search(11, -1, -1);
    run_search(0, -1, -1);
    run_search(15, -1, -1);
    run_search(8, -1, -1);
    run_search(6, -1, 1);
    run_search(13, 1, -1);
    run_search(13, -1, -1);

    // Reset during probe 3: immediate abort, no done.
    target = 9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("abort_guess", bus.guess, 0);
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_done", bus.done, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      check_eq("abort_no_done", bus.done, 0);
    end
    run_search(9, -1, -1);

    // start held high: back-to-back searches every W+2 cycles.
    target = 5;
    model(5, -1);
    bus.start = 1'b1;
    step();
    for (int i = 1; i <= exp_g.size(); i++) begin
      step();
    end
    check_eq("b2b_done", bus.done, 1);
    check_eq("b2b_result", bus.result, exp_res);
    step();
    check_eq("b2b_done_ignores_start", bus.busy, 0);
    step();
    check_eq("b2b_reaccept", bus.busy, 1);
    check_eq("b2b_guess", bus.guess, 1 << (W - 1));
    bus.start = 1'b0;
    for (int i = 0; i < exp_g.size(); i++) begin
      step();
    end
    check_eq("b2b_done2", bus.done, 1);
    check_eq("b2b_result2", bus.result, exp_res);
    step();
    step();

    // Randomized targets, occasional malformed comparator flags.
    for (int r = 0; r < 24; r++) begin
      int t;
      int fp;
      t = int'($urandom_range(0, (1 << W) - 1));
      fp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_search(t, fp, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
